ecc_uop_sequencer: RTL

Parametrised micro-op sequencer for the ECC engine. It accepts a subroutine command, fetches instructions from the micro-op program ROM between the subroutine's start and end addresses, and issues each decoded micro-op to the datapath. It stalls on point-multiply, HMAC-DRBG and SCA micro-ops until the engine signals completion, and supports abort. It sits between the ECC register-interface FSM and the arithmetic/point-multiply datapath, and generalises subroutine dispatch to any program depth, operand width and subroutine count.

---
 rtl/ecc_uop_seq_pkg.sv | 48 ++++
 rtl/ecc_uop_watchdog.sv | 33 +++
 rtl/ecc_uop_sequencer.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/ecc_uop_seq_pkg.sv
// Shared definitions for the ECC micro-op sequencer.
//   - seq_state_e    : sequencer FSM states
//   - uop_opcode_t   : {op_sel, wr_en, rd_en, pm_cmd, hmac_drbg_en, sca_en}
//   - uop_instr_t    : {opcode, reg_id, mem_addr}, mem_addr in the LSBs
//   - is_engine_op() : micro-ops that stall until the engine reports completion
//   - DEF_SUB_START / DEF_SUB_END : default dispatch table, subroutine i at bits [i*7 +: 7]
package ecc_uop_seq_pkg;

    localparam int unsigned PKG_PROG_ADDR_W = 7;
    localparam int unsigned PKG_OPR_ADDR_W  = 6;
    localparam int unsigned PKG_PM_CMD_W    = 4;
    localparam int unsigned PKG_NUM_SUB     = 8;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StIssue,
        StWait,
        StFinish
    } seq_state_e;

    typedef struct packed {
        logic                    op_sel;
        logic                    wr_en;
        logic                    rd_en;
        logic [PKG_PM_CMD_W-1:0] pm_cmd;
        logic                    hmac_drbg_en;
        logic                    sca_en;
    } uop_opcode_t;

    typedef struct packed {
        uop_opcode_t               opcode;
        logic [PKG_OPR_ADDR_W-1:0] reg_id;
        logic [PKG_OPR_ADDR_W-1:0] mem_addr;
    } uop_instr_t;

    // pm_nz is the OR-reduction of pm_cmd so the function works for any PM_CMD_W.
    function automatic logic is_engine_op(input logic pm_nz, input logic hmac_drbg_en,
                                           input logic sca_en);
        return pm_nz | hmac_drbg_en | sca_en;
    endfunction

    localparam logic [PKG_NUM_SUB*PKG_PROG_ADDR_W-1:0] DEF_SUB_START =
        {7'd91, 7'd61, 7'd41, 7'd31, 7'd21, 7'd17, 7'd14, 7'd0};
    localparam logic [PKG_NUM_SUB*PKG_PROG_ADDR_W-1:0] DEF_SUB_END =
        {7'd127, 7'd90, 7'd60, 7'd40, 7'd30, 7'd20, 7'd16, 7'd13};

endpackage

// File: rtl/ecc_uop_watchdog.sv
// Engine-wait watchdog. Counts enabled cycles since the last clear and flags
// expiry on the LIMIT-th enabled cycle.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   clear      : restart the count (held while the micro-op is being issued)
//   enable     : count this cycle
//   expired    : LIMIT enabled cycles elapsed since clear
module ecc_uop_watchdog #(
    parameter int unsigned LIMIT = 4096
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CNT_W = $clog2(LIMIT + 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt_q <= '0;
        end else if (enable && !expired) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Combinational so the FSM leaves WAIT on exactly the LIMIT-th cycle.
    assign expired = enable && (cnt_q == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/ecc_uop_sequencer.sv
// ECC micro-op sequencer: runs one subroutine of the micro-op ROM per command,
// issuing each instruction as a one-cycle uop_valid pulse and stalling on
// engine micro-ops (point-multiply, HMAC-DRBG, SCA) until engine_done.
// Optional feature: define ECC_UOP_TIMEOUT_EN to bound WAIT by TIMEOUT_CYC cycles.
// Ports:
//   clk, reset                  : clock, synchronous active-high reset
//   cmd_valid/cmd_ready/cmd_sel : subroutine request handshake
//   sub_start/sub_end           : dispatch table, subroutine i at [i*PROG_ADDR_W +: PROG_ADDR_W]
//   prog_addr/prog_instr        : program ROM port, 1-cycle read latency
//   uop_*                       : issued micro-op
//   engine_done, abort          : engine completion pulse, subroutine abort
//   busy, done, error           : status
module ecc_uop_sequencer
    import ecc_uop_seq_pkg::*;
#(
    parameter int unsigned PROG_ADDR_W = 7,
    parameter int unsigned OPR_ADDR_W  = 6,
    parameter int unsigned PM_CMD_W    = 4,
    parameter int unsigned NUM_SUB     = 8,
    parameter int unsigned SUB_W       = 3,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             cmd_valid,
    output logic                             cmd_ready,
    input  logic [SUB_W-1:0]                 cmd_sel,
    input  logic [NUM_SUB*PROG_ADDR_W-1:0]   sub_start,
    input  logic [NUM_SUB*PROG_ADDR_W-1:0]   sub_end,
    output logic [PROG_ADDR_W-1:0]           prog_addr,
    input  logic [5+PM_CMD_W+2*OPR_ADDR_W-1:0] prog_instr,
    output logic                             uop_valid,
    output logic [5+PM_CMD_W-1:0]            uop_opcode,
    output logic [OPR_ADDR_W-1:0]            uop_reg_id,
    output logic [OPR_ADDR_W-1:0]            uop_mem_addr,
    input  logic                             engine_done,
    input  logic                             abort,
    output logic                             busy,
    output logic                             done,
    output logic                             error
);

    localparam int unsigned OPC_W   = 5 + PM_CMD_W;
    localparam int unsigned INSTR_W = OPC_W + 2 * OPR_ADDR_W;

    seq_state_e             state_q;
    logic [PROG_ADDR_W-1:0] pc_q, end_q;
    logic                   uop_valid_q, done_q, error_q;
    logic [OPC_W-1:0]       opcode_q;
    logic [OPR_ADDR_W-1:0]  reg_id_q, mem_addr_q;

    // Dispatch table lookup; sel_ok is low for indices past the table.
    logic                   sel_ok;
    logic [PROG_ADDR_W-1:0] start_sel, end_sel;

    always_comb begin
        sel_ok    = 1'b0;
        start_sel = '0;
        end_sel   = '0;
        for (int i = 0; i < int'(NUM_SUB); i++) begin
            if (cmd_sel == SUB_W'(i)) begin
                sel_ok    = 1'b1;
                start_sel = sub_start[i*PROG_ADDR_W +: PROG_ADDR_W];
                end_sel   = sub_end[i*PROG_ADDR_W +: PROG_ADDR_W];
            end
        end
    end

    logic [OPC_W-1:0]      instr_opcode;
    logic [OPR_ADDR_W-1:0] instr_reg_id, instr_mem_addr;
    logic                  instr_engine;

    assign instr_opcode   = prog_instr[INSTR_W-1 -: OPC_W];
    assign instr_reg_id   = prog_instr[2*OPR_ADDR_W-1 -: OPR_ADDR_W];
    assign instr_mem_addr = prog_instr[OPR_ADDR_W-1:0];
    // Opcode LSBs: sca_en, hmac_drbg_en, then pm_cmd.
    assign instr_engine   = is_engine_op(|instr_opcode[PM_CMD_W+1:2], instr_opcode[1],
                                         instr_opcode[0]);

    logic wd_expired;

`ifdef ECC_UOP_TIMEOUT_EN
    ecc_uop_watchdog #(
        .LIMIT (TIMEOUT_CYC)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (state_q == StIssue),
        .enable  (state_q == StWait),
        .expired (wd_expired)
    );
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYC;
    assign wd_expired     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            pc_q        <= '0;
            end_q       <= '0;
            uop_valid_q <= 1'b0;
            opcode_q    <= '0;
            reg_id_q    <= '0;
            mem_addr_q  <= '0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            uop_valid_q <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            if (state_q != StIdle && abort) begin
                // Abort wins over engine_done and suppresses any pending done.
                state_q <= StIdle;
                error_q <= 1'b1;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (cmd_valid) begin
                            if (sel_ok) begin
                                pc_q    <= start_sel;
                                end_q   <= end_sel;
                                state_q <= StFetch;
                            end else begin
                                error_q <= 1'b1;
                            end
                        end
                    end
                    StFetch: state_q <= StIssue;
                    StIssue: begin
                        uop_valid_q <= 1'b1;
                        opcode_q    <= instr_opcode;
                        reg_id_q    <= instr_reg_id;
                        mem_addr_q  <= instr_mem_addr;
                        if (instr_engine) begin
                            state_q <= StWait;
                        end else if (pc_q == end_q) begin
                            state_q <= StFinish;
                        end else begin
                            pc_q    <= pc_q + 1'b1;
                            state_q <= StFetch;
                        end
                    end
                    StWait: begin
                        if (wd_expired) begin
                            state_q <= StIdle;
                            error_q <= 1'b1;
                        end else if (engine_done) begin
                            if (pc_q == end_q) begin
                                state_q <= StFinish;
                            end else begin
                                pc_q    <= pc_q + 1'b1;
                                state_q <= StFetch;
                            end
                        end
                    end
                    StFinish: begin
                        done_q  <= 1'b1;
                        state_q <= StIdle;
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign cmd_ready    = (state_q == StIdle) && !reset;
    assign busy         = (state_q != StIdle);
    assign prog_addr    = pc_q;
    assign uop_valid    = uop_valid_q;
    assign uop_opcode   = opcode_q;
    assign uop_reg_id   = reg_id_q;
    assign uop_mem_addr = mem_addr_q;
    assign done         = done_q;
    assign error        = error_q;

endmodule
